// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: deserialises start/data/parity/stop framed words from a
// 1-bit line, drops bad frames, and queues good words in a show-ahead FIFO
// behind a valid/ready handshake. Error events feed a saturating counter.
module serial_frame_receiver #(
    parameter int DATA_W      = 32,
    parameter int PARITY_MODE = 0,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                     serial_clk,
    input  logic                     rst,
    input  logic                     i_s_data,
    output logic [DATA_W-1:0]        p_data,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overrun,
    output logic [CNT_W-1:0]         err_count
);

    localparam bit PAR_EN = (PARITY_MODE != 0);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, RESYNC} state_t;

    state_t               state;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_acc;
    logic [DATA_W-1:0]    shreg;
    logic                 push_vld;
    logic [DATA_W-1:0]    push_data;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;

    // par_acc holds the XOR of all data bits plus the received parity bit.
    function automatic logic parity_ok(input logic acc);
        if (PARITY_MODE == 1)      parity_ok = ~acc;
        else if (PARITY_MODE == 2) parity_ok = acc;
        else                       parity_ok = 1'b1;
    endfunction

    // Frame FSM: tracks position in the frame and issues push / error pulses.
    always_ff @(posedge serial_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            par_acc    <= 1'b0;
            push_vld   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            push_vld   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_s_data) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    par_acc <= par_acc ^ i_s_data;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == IDX_W'(DATA_W - 1))
                        state <= PAR_EN ? PAR : STOP;
                end
                PAR: begin
                    par_acc <= par_acc ^ i_s_data;
                    state   <= STOP;
                end
                STOP: begin
                    if (i_s_data) begin
                        frame_err <= 1'b1;
                        state     <= RESYNC;
                    end else if (!parity_ok(par_acc)) begin
                        parity_err <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        push_vld <= 1'b1;
                        state    <= IDLE;
                    end
                end
                RESYNC: begin
                    // A high line here may be the tail of a broken frame, so
                    // wait for idle before accepting another start bit.
                    if (!i_s_data) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: LSB-first shift register and the word handed to the FIFO.
    always_ff @(posedge serial_clk) begin
        if (state == DATA) shreg <= {i_s_data, shreg[DATA_W-1:1]};
        if (state == STOP) push_data <= shreg;
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign p_valid = (count != '0);
    assign do_pop  = p_valid & p_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_vld & (~full | do_pop);

    // FIFO control, overrun detection and saturating error counter.
    always_ff @(posedge serial_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            overrun <= push_vld & full & ~do_pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if ((frame_err | parity_err | overrun) && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    // FIFO storage; written one edge after the stop bit, never bypassed.
    always_ff @(posedge serial_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign fifo_level = count;
    assign p_data     = p_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a default 32-bit/no-parity instance
// (A) and an 8-bit even-parity instance (B) share the clock and reset.
module tb_serial_frame_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic line_a = 1'b0, ready_a = 1'b0;
    logic line_b = 1'b0, ready_b = 1'b0;

    logic [31:0] data_a;
    logic        valid_a, ferr_a, perr_a, ovr_a;
    logic [2:0]  level_a;
    logic [7:0]  ecnt_a;
    logic [7:0]  data_b;
    logic        valid_b, ferr_b, perr_b, ovr_b;
    logic [2:0]  level_b;
    logic [7:0]  ecnt_b;

    serial_frame_receiver #(.DATA_W(32), .PARITY_MODE(0), .DEPTH(4), .CNT_W(8)) dut_a (
        .serial_clk(clk), .rst(rst_n), .i_s_data(line_a),
        .p_data(data_a), .p_valid(valid_a), .p_ready(ready_a), .fifo_level(level_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a), .err_count(ecnt_a));

    serial_frame_receiver #(.DATA_W(8), .PARITY_MODE(1), .DEPTH(4), .CNT_W(8)) dut_b (
        .serial_clk(clk), .rst(rst_n), .i_s_data(line_b),
        .p_data(data_b), .p_valid(valid_b), .p_ready(ready_b), .fifo_level(level_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b), .err_count(ecnt_b));

    int checks = 0;
    int errors = 0;

    // Words popped and pulse cycles seen, sampled mid-cycle.
    logic [31:0] q_a[$];
    logic [7:0]  q_b[$];
    int nf_a = 0, np_a = 0, no_a = 0;
    int nf_b = 0, np_b = 0, no_b = 0;

    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back(data_a);
        if (valid_b && ready_b) q_b.push_back(data_b);
        if (ferr_a) nf_a++;
        if (perr_a) np_a++;
        if (ovr_a)  no_a++;
        if (ferr_b) nf_b++;
        if (perr_b) np_b++;
        if (ovr_b)  no_b++;
    end

    task automatic clear_mon();
        q_a.delete(); q_b.delete();
        nf_a = 0; np_a = 0; no_a = 0; nf_b = 0; np_b = 0; no_b = 0;
    endtask

    task automatic drive_a(input logic b);
        @(posedge clk); #1; line_a = b;
    endtask

    task automatic drive_b(input logic b);
        @(posedge clk); #1; line_b = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; line_a = 1'b0; line_b = 1'b0; end
    endtask

    // Start bit plus 32 data bits, LSB first.
    task automatic send_body_a(input logic [31:0] d);
        drive_a(1'b1);
        for (int i = 0; i < 32; i++) drive_a(d[i]);
    endtask

    // Leaves the stop bit on the line; the next rising edge is the stop edge.
    task automatic send_a(input logic [31:0] d, input logic stop);
        send_body_a(d);
        drive_a(stop);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic stop);
        drive_b(1'b1);
        for (int i = 0; i < 8; i++) drive_b(d[i]);
        drive_b(par);
        drive_b(stop);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        idle(3);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level_a: got %0d expected 0", level_a); end
        checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", data_a); end
        checks++; if ({ferr_a, perr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL reset_pulses_a: got %b expected 000", {ferr_a, perr_a, ovr_a}); end
        checks++; if (ecnt_a !== 8'd0) begin errors++; $display("FAIL reset_ecnt_a: got %0d expected 0", ecnt_a); end
        checks++; if ({valid_b, level_b, data_b, ecnt_b} !== 20'h0) begin errors++; $display("FAIL reset_b: got %h expected 0", {valid_b, level_b, data_b, ecnt_b}); end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_frame();
        clear_mon();
        ready_a = 1'b1;
        send_a(32'hA5A5_0F0F, 1'b0);
        drive_a(1'b0);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_valid_at_stop: got %b expected 0", valid_a); end
        drive_a(1'b0);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL t1_valid_next: got %b expected 1", valid_a); end
        checks++; if (data_a !== 32'hA5A5_0F0F) begin errors++; $display("FAIL t1_data: got %h expected a5a50f0f", data_a); end
        drive_a(1'b0);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_valid_after_pop: got %b expected 0", valid_a); end
        checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL t1_count: got %0d expected 1", q_a.size()); end
    endtask

    task automatic test_frame_error();
        clear_mon();
        ready_a = 1'b1;
        send_a(32'h0000_1234, 1'b1);
        repeat (5) drive_a(1'b1);
        idle(2);
        send_a(32'h1, 1'b0);
        idle(4);
        checks++; if (nf_a !== 1) begin errors++; $display("FAIL t2_frame_err_pulses: got %0d expected 1", nf_a); end
        checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL t2_words: got %0d expected 1", q_a.size()); end
        else begin
            checks++; if (q_a[0] !== 32'h1) begin errors++; $display("FAIL t2_word: got %h expected 1", q_a[0]); end
        end
        checks++; if (ecnt_a !== 8'd1) begin errors++; $display("FAIL t2_ecnt: got %0d expected 1", ecnt_a); end
    endtask

    task automatic test_parity();
        clear_mon();
        ready_b = 1'b1;
        send_b(8'h03, 1'b1, 1'b0);
        idle(4);
        checks++; if (np_b !== 1) begin errors++; $display("FAIL t3_parity_err_pulses: got %0d expected 1", np_b); end
        checks++; if (q_b.size() !== 0 || level_b !== 3'd0) begin errors++; $display("FAIL t3_no_push: got %0d words expected 0", q_b.size()); end
        send_b(8'h03, 1'b0, 1'b0);
        idle(4);
        checks++; if (q_b.size() !== 1) begin errors++; $display("FAIL t3_words: got %0d expected 1", q_b.size()); end
        else begin
            checks++; if (q_b[0] !== 8'h03) begin errors++; $display("FAIL t3_word: got %h expected 03", q_b[0]); end
        end
        checks++; if (np_b !== 1 || nf_b !== 0) begin errors++; $display("FAIL t3_err_total: got %0d/%0d expected 1/0", np_b, nf_b); end
        checks++; if (ecnt_b !== 8'd1) begin errors++; $display("FAIL t3_ecnt: got %0d expected 1", ecnt_b); end
    endtask

    task automatic test_saturation();
        clear_mon();
        for (int k = 0; k < 260; k++) send_b(8'h01, 1'b0, 1'b0);
        idle(4);
        checks++; if (np_b !== 260) begin errors++; $display("FAIL sat_pulses: got %0d expected 260", np_b); end
        checks++; if (ecnt_b !== 8'd255) begin errors++; $display("FAIL sat_ecnt: got %0d expected 255", ecnt_b); end
        checks++; if (q_b.size() !== 0) begin errors++; $display("FAIL sat_no_push: got %0d expected 0", q_b.size()); end
    endtask

    task automatic test_overrun();
        logic [31:0] exp_w [4];
        clear_mon();
        ready_a = 1'b0;
        for (int k = 1; k <= 5; k++) send_a(32'(k), 1'b0);
        idle(4);
        checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL t4_level: got %0d expected 4", level_a); end
        checks++; if (no_a !== 1) begin errors++; $display("FAIL t4_overrun_pulses: got %0d expected 1", no_a); end
        checks++; if (ecnt_a !== 8'd2) begin errors++; $display("FAIL t4_ecnt: got %0d expected 2", ecnt_a); end
        ready_a = 1'b1;
        idle(6);
        ready_a = 1'b0;
        exp_w = '{32'd1, 32'd2, 32'd3, 32'd4};
        checks++; if (q_a.size() !== 4) begin errors++; $display("FAIL t4_pop_count: got %0d expected 4", q_a.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (q_a[i] !== exp_w[i]) begin errors++; $display("FAIL t4_pop_%0d: got %h expected %h", i, q_a[i], exp_w[i]); end
            end
        end
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL t4_level_empty: got %0d expected 0", level_a); end
    endtask

    task automatic test_back_to_back_full_pop();
        logic [31:0] exp_w [5];
        clear_mon();
        ready_a = 1'b0;
        for (int k = 0; k < 4; k++) send_a(32'h11 + 32'(k), 1'b0);
        send_body_a(32'h15);
        drive_a(1'b0);
        ready_a = 1'b1;
        @(posedge clk); #1; ready_a = 1'b0; line_a = 1'b0;
        idle(4);
        checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL t5_level: got %0d expected 4", level_a); end
        checks++; if (no_a !== 0) begin errors++; $display("FAIL t5_overrun: got %0d expected 0", no_a); end
        checks++; if (ecnt_a !== 8'd2) begin errors++; $display("FAIL t5_ecnt: got %0d expected 2", ecnt_a); end
        ready_a = 1'b1;
        idle(6);
        ready_a = 1'b0;
        exp_w = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
        checks++; if (q_a.size() !== 5) begin errors++; $display("FAIL t5_pop_count: got %0d expected 5", q_a.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (q_a[i] !== exp_w[i]) begin errors++; $display("FAIL t5_pop_%0d: got %h expected %h", i, q_a[i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        clear_mon();
        ready_a = 1'b1;
        drive_a(1'b1);
        for (int i = 0; i < 10; i++) drive_a(1'b1);
        rst_n = 1'b0;
        line_a = 1'b0;
        idle(2);
        checks++; if ({valid_a, level_a, ecnt_a} !== 12'h0 || data_a !== 32'h0) begin errors++; $display("FAIL t6_in_reset_a: got %h/%h expected 0", {valid_a, level_a, ecnt_a}, data_a); end
        checks++; if (ecnt_b !== 8'd0) begin errors++; $display("FAIL t6_in_reset_ecnt_b: got %0d expected 0", ecnt_b); end
        rst_n = 1'b1;
        idle(2);
        send_a(32'hDEAD_BEEF, 1'b0);
        idle(4);
        checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL t6_words: got %0d expected 1", q_a.size()); end
        else begin
            checks++; if (q_a[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t6_word: got %h expected deadbeef", q_a[0]); end
        end
        checks++; if (ecnt_a !== 8'd0 || nf_a !== 0) begin errors++; $display("FAIL t6_ecnt: got %0d/%0d expected 0/0", ecnt_a, nf_a); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_frame_error();
        test_parity();
        test_saturation();
        test_overrun();
        test_back_to_back_full_pop();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
